sap_program_loader: RTL and testbench
=====================================

Name: sap_program_loader

Overview:
- Sequences program loading into the SAP 16x8 RAM before a run; the SAP-1 equivalent of the program/run switch.
- Accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive RAM addresses starting at 0.
- Holds the CPU in clear during loading and releases it when loading completes.
- Sits between the host/testbench byte source and the RAM write port; RAM write mux select is driven by cpu_hold.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width.
- MEM_DEPTH, 16, number of RAM words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  level-sampled load request; honoured only in IDLE.
- prog_len  input  ADDR_W+1  number of bytes to load, legal 1..MEM_DEPTH; sampled with start.
- in_valid  input  1  byte source has data.
- in_data  input  DATA_W  byte to load.
- in_ready  output  1  loader accepts a byte this cycle.
- ram_we  output  1  RAM write strobe, one cycle per byte.
- ram_addr  output  ADDR_W  RAM write address.
- ram_wdata  output  DATA_W  RAM write data.
- cpu_hold  output  1  forces CPU clear; RAM port owned by loader while high.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when loading completes.
- err  output  1  sticky; set on illegal prog_len, cleared by next legal start or reset.

Behaviour:
- Reset (async, clrn=0): state=IDLE. in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=0, busy=0, done=0, err=0. Byte count=0.
- Reset mid-load aborts immediately. Partially written RAM contents are left as-is. No done pulse.
- IDLE, start=1:
  - prog_len==0 or prog_len>MEM_DEPTH: set err, stay in IDLE, cpu_hold stays 0.
  - Otherwise: latch len, clear err, addr=0, count=0, cpu_hold=1, go to WAIT.
- WAIT: in_ready=1.
  - On in_valid&&in_ready: register in_data into ram_wdata, go to WRITE.
  - No valid: stay in WAIT indefinitely; no timeout.
- WRITE: ram_we=1 for exactly this cycle; in_ready=0; ram_addr/ram_wdata stable.
  - Next cycle: count+1.
  - If count+1==len: go to FINISH.
  - Else: addr+1, go to WAIT.
- FINISH (one cycle): done=1, cpu_hold=0, go to IDLE.
- Throughput: at most one byte per 2 cycles. Latency from accepting byte k to its write strobe: 1 cycle.
- Address never wraps. len=16 writes addresses 0..15 and stops; the count is ADDR_W+1 bits wide so 16 is representable.
- start while busy is ignored. prog_len changes while busy are ignored.
- in_valid while in_ready=0: data is not consumed; the source must hold it.
- busy=1 in WAIT, WRITE and FINISH.
- cpu_hold=1 from the cycle after an accepted start through the last WRITE.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_W-1:0] holding the mod-2^DATA_W sum of all bytes written in the current load.
  - Cleared on accepted start and on reset; updated in the WRITE cycle.
  - Valid and stable from the done pulse until the next accepted start.
- When undefined: port and adder are absent; all other behaviour is identical.

Decomposition:
- sap_pkg gains:
  - typedef enum LOADER_STATE_t {L_IDLE, L_WAIT, L_WRITE, L_FINISH}.
  - localparam SAP_MEM_DEPTH=16.
- No sub-module. Address/count registers and the FSM live in one always_ff with a separate combinational output decode.

Test Plan:
- Reset mid-load: clrn low during WAIT at addr 5 -> all outputs 0, state IDLE, cpu_hold=0 same cycle, no done pulse.
- Basic load: start with prog_len=3, in_valid held high with bytes 0x09,0x1A,0x2B -> ram_we pulses at addrs 0,1,2 with those data, 2 cycles apart. done pulses one cycle after the third write; cpu_hold falls in the same cycle.
- Full memory and backpressure: prog_len=16 with in_valid toggled randomly -> exactly 16 writes, addrs 0..15 in order, no write while in_valid was low, no address wrap, done once.
- Illegal length: prog_len=0, then prog_len=17 -> err=1, busy=0, no ram_we. A following start with prog_len=1 clears err and completes normally.
- Start while busy: start re-asserted with prog_len=2 during a 4-byte load -> ignored; 4 writes, single done.
- Checksum (LOADER_CHECKSUM_EN): bytes 0xF0,0x20,0x05 -> checksum=0x15 at done, held until the next start.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP types: program-loader FSM states and the default RAM depth.
package sap_pkg;

  localparam int SAP_MEM_DEPTH = 16;

  typedef enum logic [1:0] {
    L_IDLE,
    L_WAIT,
    L_WRITE,
    L_FINISH
  } LOADER_STATE_t;

endpackage

// File: rtl/sap_program_loader_if.sv
// Host/RAM/CPU-control bundle for the SAP program loader.
// Optional checksum signal is present when LOADER_CHECKSUM_EN is defined.
interface sap_program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  // Loader side.
  modport slave (
    input  start, prog_len, in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, busy, done, err
`ifdef LOADER_CHECKSUM_EN
    , output checksum
`endif
  );

  // Host / byte-source side.
  modport master (
    output start, prog_len, in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, busy, done, err
`ifdef LOADER_CHECKSUM_EN
    , input checksum
`endif
  );

endinterface

// File: rtl/sap_program_loader.sv
// SAP-1 program/run sequencer: streams bytes into RAM from address 0 while holding the CPU.
// Define LOADER_CHECKSUM_EN to add a running mod-2^DATA_W checksum output.
module sap_program_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = SAP_MEM_DEPTH
) (
  input  logic                clk,
  input  logic                clrn,
  sap_program_loader_if.slave bus
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MEM_DEPTH);

  LOADER_STATE_t     r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
`endif

  logic            w_len_ok;
  logic [ADDR_W:0] w_count_nxt;
  logic            w_last;

  assign w_len_ok    = (bus.prog_len != '0) && (bus.prog_len <= LEN_MAX);
  assign w_count_nxt = r_count + 1'b1;
  // Count is one bit wider than the address so a full-depth load terminates without wrapping.
  assign w_last      = (w_count_nxt == r_len);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= L_IDLE;
      r_len   <= '0;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      case (r_state)
        L_IDLE: begin
          if (bus.start) begin
            if (w_len_ok) begin
              r_len   <= bus.prog_len;
              r_err   <= 1'b0;
              r_addr  <= '0;
              r_count <= '0;
`ifdef LOADER_CHECKSUM_EN
              r_csum  <= '0;
`endif
              r_state <= L_WAIT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        L_WAIT: begin
          if (bus.in_valid) begin
            r_wdata <= bus.in_data;
            r_state <= L_WRITE;
          end
        end
        L_WRITE: begin
          r_count <= w_count_nxt;
`ifdef LOADER_CHECKSUM_EN
          r_csum  <= r_csum + r_wdata;
`endif
          if (w_last) begin
            r_state <= L_FINISH;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= L_WAIT;
          end
        end
        L_FINISH: r_state <= L_IDLE;
        default:  r_state <= L_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so async reset clears them immediately.
  assign bus.in_ready  = (r_state == L_WAIT);
  assign bus.ram_we    = (r_state == L_WRITE);
  assign bus.cpu_hold  = (r_state == L_WAIT) || (r_state == L_WRITE);
  assign bus.busy      = (r_state != L_IDLE);
  assign bus.done      = (r_state == L_FINISH);
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.err       = r_err;
`ifdef LOADER_CHECKSUM_EN
  assign bus.checksum  = r_csum;
`endif

endmodule

// File: tb/tb_sap_program_loader.sv
// Self-checking bench for sap_program_loader: start-response table, directed corner cases,
// and randomized loads against a byte-list reference model (checksum when LOADER_CHECKSUM_EN).
module tb_sap_program_loader;

  logic clk;
  logic clrn;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] src [16];

  sap_program_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  sap_program_loader #(.ADDR_W(4), .DATA_W(8), .MEM_DEPTH(16)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] len;
    bit         exp_err;
    int         vprob;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  0);
    check({tag, "_ram_we"},    bus.ram_we,    0);
    check({tag, "_ram_addr"},  bus.ram_addr,  0);
    check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    check({tag, "_cpu_hold"},  bus.cpu_hold,  0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
    check({tag, "_err"},       bus.err,       0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_checksum"},  bus.checksum,  0);
`endif
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
  endtask

  // Presents start for one sampling edge; returns at the negedge after it.
  task automatic do_start(input logic [4:0] len);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.prog_len = len;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.prog_len = 5'($urandom);
  endtask

  // Reference: a load of len bytes writes src[0..len-1] to addresses 0..len-1 in order,
  // each write one cycle after its handshake, then exactly one done right after the last write.
  task automatic feed(input int len, input int vprob, input bit poke_start);
    int idx = 0;
    int nw = 0;
    int cyc = 0;
    int last_w = -100;
    bit acc = 1'b0;
    bit seen = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum = 8'h00;
`endif
    while (!seen && cyc < 400) begin
      if (bus.ram_we) begin
        check("wr_follows_accept", acc, 1);
        check("wr_ready_low", bus.in_ready, 0);
        if (nw < 16) begin
          check("wr_addr", bus.ram_addr, nw);
          check("wr_data", bus.ram_wdata, src[nw]);
`ifdef LOADER_CHECKSUM_EN
          sum = sum + src[nw];
`endif
        end
        nw++;
        last_w = cyc;
      end
      if (bus.done) begin
        seen = 1'b1;
        check("done_after_last_wr", cyc, last_w + 1);
        check("hold_at_done", bus.cpu_hold, 0);
        check("busy_at_done", bus.busy, 1);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_at_done", bus.checksum, sum);
`endif
      end else begin
        check("busy_loading", bus.busy, 1);
        check("hold_loading", bus.cpu_hold, 1);
        bus.in_valid = (idx < len) && ($urandom_range(0, 99) < vprob);
        bus.in_data  = bus.in_valid ? src[idx] : 8'($urandom);
        acc = bus.in_ready && bus.in_valid;
        if (acc) idx++;
        bus.start    = poke_start && (cyc == 2);
        bus.prog_len = bus.start ? 5'd2 : 5'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check("done_seen", seen, 1);
    check("write_count", nw, len);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_we", bus.ram_we, 0);
      check("idle_done", bus.done, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_hold", bus.cpu_hold, 0);
`ifdef LOADER_CHECKSUM_EN
      check("checksum_held", bus.checksum, sum);
`endif
    end
  endtask

  task automatic check_started(input string tag);
    check({tag, "_busy"},  bus.busy, 1);
    check({tag, "_hold"},  bus.cpu_hold, 1);
    check({tag, "_ready"}, bus.in_ready, 1);
    check({tag, "_err"},   bus.err, 0);
    check({tag, "_addr"},  bus.ram_addr, 0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_csum_clr"}, bus.checksum, 0);
`endif
  endtask

  initial begin
    vec_t tbl [6];
    int   guard;
    tbl[0] = '{len: 5'd0,  exp_err: 1'b1, vprob: 0};
    tbl[1] = '{len: 5'd17, exp_err: 1'b1, vprob: 0};
    tbl[2] = '{len: 5'd31, exp_err: 1'b1, vprob: 0};
    tbl[3] = '{len: 5'd1,  exp_err: 1'b0, vprob: 100};
    tbl[4] = '{len: 5'd16, exp_err: 1'b0, vprob: 50};
    tbl[5] = '{len: 5'd5,  exp_err: 1'b0, vprob: 70};

    clrn         = 1'b0;
    bus.start    = 1'b0;
    bus.prog_len = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    clrn = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst");

    // Basic load with in_valid held high.
    src[0] = 8'h09; src[1] = 8'h1A; src[2] = 8'h2B;
    do_start(5'd3);
    check_started("basic");
    feed(3, 100, 1'b0);

    // Start-response table; legal entries run a randomized load to completion.
    foreach (tbl[i]) begin
      fill_random();
      do_start(tbl[i].len);
      check("tbl_err",  bus.err, tbl[i].exp_err);
      check("tbl_busy", bus.busy, !tbl[i].exp_err);
      check("tbl_hold", bus.cpu_hold, !tbl[i].exp_err);
      if (tbl[i].exp_err) begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("bad_len_we",   bus.ram_we, 0);
          check("bad_len_busy", bus.busy, 0);
          check("bad_len_err",  bus.err, 1);
        end
      end else begin
        feed(tbl[i].len, tbl[i].vprob, 1'b0);
      end
    end

    // Start re-asserted mid-load must be ignored.
    fill_random();
    do_start(5'd4);
    check_started("busy_start");
    feed(4, 70, 1'b1);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 16);
      fill_random();
      do_start(5'(len));
      check_started("rand");
      feed(len, $urandom_range(30, 100), 1'b0);
    end

    // Checksum wraps mod 256: F0+20+05 = 0x115 -> 0x15.
    src[0] = 8'hF0; src[1] = 8'h20; src[2] = 8'h05;
    do_start(5'd3);
    check_started("csum");
    feed(3, 100, 1'b0);

    // Reset during WAIT at address 5 aborts at once with no done.
    fill_random();
    do_start(5'd8);
    guard = 0;
    while (!(bus.in_ready && bus.ram_addr == 4'd5) && guard < 100) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      guard++;
    end
    check("reach_addr5", guard < 100, 1);
    bus.in_valid = 1'b0;
    clrn = 1'b0;
    #1;
    check_all_zero("mid_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_done", bus.done, 0);
    end
    clrn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("after_rst_done", bus.done, 0);
      check("after_rst_busy", bus.busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
